// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types and constants for the memory subsystem.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  localparam word_t       RAM_ERR_WORD    = 32'hBAD1BAD1;
  localparam int unsigned RAM_LAT_DEFAULT = 2;

endpackage

// File: rtl/ram_wait_counter.sv
// 4-bit wait-state down-counter: parallel load, saturating decrement, zero flag.
module ram_wait_counter (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       dec_i,
  output logic       zero_o
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/memory_access_controller.sv
// Bridges coherency-controller RAM requests onto a single-port SRAM, inserting
// LAT wait cycles per transaction and flagging malformed requests.
module memory_access_controller
  import cpu_types_pkg::*;
#(
  parameter  int unsigned LAT       = RAM_LAT_DEFAULT,
  parameter  int unsigned MEM_WORDS = 16384,
  localparam int unsigned AW        = $clog2(MEM_WORDS)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            ramREN,
  input  logic            ramWEN,
  input  word_t           ramaddr,
  input  word_t           ramstore,
  output ramstate_t       ramstate,
  output word_t           ramload,
  output logic            mem_en,
  output logic            mem_wen,
  output logic [AW-1:0]   mem_addr,
  output word_t           mem_wdata,
  input  word_t           mem_rdata
);

  localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) << 2;
  localparam logic [3:0]  LAT_RELOAD = 4'(LAT - 1);

  ramstate_t     state_q, state_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic          op_q, op_d;
  word_t         store_q, store_d;

  logic req, invalid, changed;
  logic cnt_load, cnt_dec, cnt_zero;
  logic access_c;

  assign req     = ramREN | ramWEN;
  assign invalid = (ramREN & ramWEN) | (ramaddr[1:0] != 2'b00) |
                   ({1'b0, ramaddr} >= ADDR_LIMIT);
  // Only the word address is latched; invalid is always checked first, so
  // byte-offset or out-of-range bits can never alias an unchanged request.
  assign changed = (ramaddr[AW+1:2] != waddr_q) | (ramWEN != op_q) |
                   (ramstore != store_q);

  ram_wait_counter u_wait (
    .clk_i      (CLK),
    .rst_i      (RST),
    .load_i     (cnt_load),
    .load_val_i (LAT_RELOAD),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    access_c = 1'b0;
    ramload  = '0;
    waddr_d  = waddr_q;
    op_d     = op_q;
    store_d  = store_q;

    unique case (state_q)
      FREE: begin
        if (req) begin
          if (invalid) begin
            state_d = ERROR;
          end else begin
            state_d  = BUSY;
            cnt_load = 1'b1;
          end
        end
      end
      BUSY: begin
        if (!req) begin
          state_d = FREE;
        end else if (invalid) begin
          state_d = ERROR;
        end else if (changed) begin
          cnt_load = 1'b1;
        end else if (cnt_zero) begin
          access_c = 1'b1;
          state_d  = ACCESS;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ACCESS: begin
        ramload = op_q ? '0 : mem_rdata;
        if (!req) begin
          state_d = FREE;
        end else if (invalid) begin
          state_d = ERROR;
        end else begin
          state_d  = BUSY;
          cnt_load = 1'b1;
        end
      end
      ERROR: begin
        ramload = RAM_ERR_WORD;
        if (!req) begin
          state_d = FREE;
        end
      end
    endcase

    if (cnt_load) begin
      waddr_d = ramaddr[AW+1:2];
      op_d    = ramWEN;
      store_d = ramstore;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= FREE;
      waddr_q <= '0;
      op_q    <= 1'b0;
      store_q <= '0;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      op_q    <= op_d;
      store_q <= store_d;
    end
  end

  assign ramstate  = state_q;
  assign mem_en    = access_c & ~RST;
  assign mem_wen   = mem_en & op_q;
  assign mem_addr  = waddr_q;
  assign mem_wdata = store_q;

endmodule

// File: tb/tb_memory_access_controller.sv
// Directed and randomized checks of memory_access_controller against a
// behavioural SRAM and a transaction-level reference model.
module tb_memory_access_controller;
  import cpu_types_pkg::*;

  localparam int unsigned LAT       = 2;
  localparam int unsigned MEM_WORDS = 16384;
  localparam int unsigned AW        = $clog2(MEM_WORDS);

  logic          CLK = 1'b0;
  logic          RST;
  logic          ramREN, ramWEN;
  logic [31:0]   ramaddr, ramstore;
  ramstate_t     ramstate;
  logic [31:0]   ramload;
  logic          mem_en, mem_wen;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;

  int n_assert = 0;
  int n_fail   = 0;

  // Behavioural SRAM with a backdoor preload port and access statistics.
  bit [31:0] mem [MEM_WORDS];
  int        acc_cnt [MEM_WORDS];
  int        wr_total = 0;
  logic          bd_we = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [31:0]   bd_data = '0;

  // Transaction-level expectation of SRAM contents.
  bit [31:0] ref_mem [MEM_WORDS];

  memory_access_controller #(.LAT(LAT), .MEM_WORDS(MEM_WORDS)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .ramREN    (ramREN),
    .ramWEN    (ramWEN),
    .ramaddr   (ramaddr),
    .ramstore  (ramstore),
    .ramstate  (ramstate),
    .ramload   (ramload),
    .mem_en    (mem_en),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    if (mem_en) begin
      acc_cnt[mem_addr] <= acc_cnt[mem_addr] + 1;
      if (mem_wen) begin
        mem[mem_addr] <= mem_wdata;
        wr_total      <= wr_total + 1;
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input int unsigned word, input logic [31:0] data);
    bd_addr = AW'(word);
    bd_data = data;
    bd_we   = 1'b1;
    tick();
    bd_we   = 1'b0;
    ref_mem[word] = data;
  endtask

  task automatic idle();
    ramREN = 1'b0;
    ramWEN = 1'b0;
  endtask

  // A valid transaction from FREE: LAT cycles in BUSY, one in ACCESS, then FREE.
  task automatic txn(input bit wr, input logic [31:0] addr, input logic [31:0] data);
    int unsigned word = addr[AW+1:2];
    int w0 = wr_total;
    ramREN = ~wr; ramWEN = wr; ramaddr = addr; ramstore = data;
    for (int k = 0; k < int'(LAT); k++) begin
      tick();
      chk("busy_state", 32'(ramstate), 32'(BUSY));
      chk("busy_load", ramload, 32'd0);
      chk("busy_en", 32'(mem_en), (k == int'(LAT) - 1) ? 32'd1 : 32'd0);
      if (k == int'(LAT) - 1) begin
        chk("busy_addr", 32'(mem_addr), word);
        chk("busy_wen", 32'(mem_wen), 32'(wr));
        if (wr) chk("busy_wdata", mem_wdata, data);
      end
    end
    tick();
    chk("acc_state", 32'(ramstate), 32'(ACCESS));
    chk("acc_load", ramload, wr ? 32'd0 : ref_mem[word]);
    chk("acc_en", 32'(mem_en), 32'd0);
    if (wr) ref_mem[word] = data;
    chk("write_count", wr_total, w0 + (wr ? 1 : 0));
    idle();
    tick();
    chk("free_state", 32'(ramstate), 32'(FREE));
    chk("free_load", ramload, 32'd0);
  endtask

  task automatic err_txn(input bit ren, input bit wen, input logic [31:0] addr, input int hold);
    int w0 = wr_total;
    ramREN = ren; ramWEN = wen; ramaddr = addr; ramstore = $urandom;
    for (int k = 0; k < hold; k++) begin
      tick();
      chk("err_state", 32'(ramstate), 32'(ERROR));
      chk("err_load", ramload, RAM_ERR_WORD);
      chk("err_en", 32'(mem_en), 32'd0);
    end
    idle();
    tick();
    chk("err_free", 32'(ramstate), 32'(FREE));
    chk("err_nowrite", wr_total, w0);
  endtask

  initial begin
    ramstate_t seq [6];
    int        acc4, w0;
    RST = 1'b1; idle(); ramaddr = '0; ramstore = '0;
    tick(); tick();
    chk("rst_en_during", 32'(mem_en), 32'd0);
    RST = 1'b0;
    chk("rst_state", 32'(ramstate), 32'(FREE));
    chk("rst_load", ramload, 32'd0);
    chk("rst_wen", 32'(mem_wen), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);

    // Single read of word 4.
    poke(4, 32'hDEADBEEF);
    txn(1'b0, 32'h10, 32'h0);

    // Write then read back word 8.
    txn(1'b1, 32'h20, 32'hCAFEF00D);
    txn(1'b0, 32'h20, 32'h0);
    chk("wr8_count", acc_cnt[8], 2);

    // Back-to-back reads with ramREN held.
    poke(4, 32'h11111111);
    poke(5, 32'h22222222);
    seq = '{BUSY, BUSY, ACCESS, BUSY, BUSY, ACCESS};
    ramREN = 1'b1; ramWEN = 1'b0; ramaddr = 32'h10; ramstore = '0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("burst_state", 32'(ramstate), 32'(seq[i]));
      if (i == 2) begin
        chk("burst_load0", ramload, 32'h11111111);
        ramaddr = 32'h14;
      end
      if (i == 5) chk("burst_load1", ramload, 32'h22222222);
    end
    idle();
    tick();
    chk("burst_free", 32'(ramstate), 32'(FREE));

    // Address change during the first BUSY cycle reloads the wait counter.
    poke(12, 32'h12121212);
    acc4 = acc_cnt[4];
    ramREN = 1'b1; ramaddr = 32'h10;
    tick();
    ramaddr = 32'h30;
    tick();
    chk("chg_busy", 32'(ramstate), 32'(BUSY));
    chk("chg_en0", 32'(mem_en), 32'd0);
    tick();
    chk("chg_en1", 32'(mem_en), 32'd1);
    chk("chg_addr", 32'(mem_addr), 32'd12);
    tick();
    chk("chg_acc", 32'(ramstate), 32'(ACCESS));
    chk("chg_load", ramload, 32'h12121212);
    chk("chg_word4", acc_cnt[4], acc4);
    idle();
    tick();

    // Invalid requests.
    err_txn(1'b1, 1'b0, 32'h0000_0013, 2);
    err_txn(1'b1, 1'b0, 32'h0001_0000, 3);
    err_txn(1'b1, 1'b1, 32'h0000_0010, 1);
    err_txn(1'b0, 1'b1, 32'hFFFF_FFFC, 2);

    // Reset in the final BUSY cycle of a write aborts it.
    poke(16, 32'h01234567);
    w0 = wr_total;
    ramWEN = 1'b1; ramaddr = 32'h40; ramstore = 32'h55AA55AA;
    tick();
    tick();
    RST = 1'b1; idle();
    #1;
    chk("rst_abort_en", 32'(mem_en), 32'd0);
    chk("rst_abort_wen", 32'(mem_wen), 32'd0);
    tick();
    RST = 1'b0;
    chk("rst_abort_state", 32'(ramstate), 32'(FREE));
    chk("rst_abort_addr", 32'(mem_addr), 32'd0);
    chk("rst_abort_nowr", wr_total, w0);
    txn(1'b0, 32'h40, 32'h0);

    // Randomized transactions against the reference model.
    for (int i = 0; i < 40; i++) begin
      int unsigned r = $urandom_range(0, 9);
      logic [31:0] a = {$urandom_range(0, 31), 2'b00};
      if (r == 0) begin
        err_txn(1'b1, 1'b0, a | 32'($urandom_range(1, 3)), $urandom_range(1, 3));
      end else if (r == 1) begin
        w0 = wr_total;
        ramWEN = 1'b1; ramREN = 1'b0; ramaddr = a; ramstore = $urandom;
        tick();
        idle();
        tick();
        chk("abort_free", 32'(ramstate), 32'(FREE));
        chk("abort_nowr", wr_total, w0);
      end else begin
        txn(r[0], a, $urandom);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no completion expected $finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/memory_access_controller.md
MEMORY_ACCESS_CONTROLLER -- requirements
Module: memory_access_controller

Interface
REQ-001 Parameter LAT, default 2: wait cycles before ACCESS; legal range 1..15.
REQ-002 Parameter MEM_WORDS, default 16384: number of 32-bit words in the backing SRAM (64 KB).
REQ-003 CLK  in  1  single clock; all state changes on its rising edge.
REQ-004 RST  in  1  reset, synchronous, active-high.
REQ-005 ramREN  in  1  read request from the coherency controller, held until serviced.
REQ-006 ramWEN  in  1  write request from the coherency controller, held until serviced.
REQ-007 ramaddr  in  32  byte address of the request.
REQ-008 ramstore  in  32  write data.
REQ-009 ramstate  out  ramstate_t  FREE/BUSY/ACCESS/ERROR, equal to the current FSM state.
REQ-010 ramload  out  32  read data.
REQ-011 mem_en  out  1  SRAM enable.
REQ-012 mem_wen  out  1  SRAM write enable.
REQ-013 mem_addr  out  $clog2(MEM_WORDS)  SRAM word address, equal to ramaddr[..:2].
REQ-014 mem_wdata  out  32  SRAM write data.
REQ-015 mem_rdata  in  32  SRAM read data, valid the cycle after mem_en with mem_wen=0.

Function
REQ-016 The FSM SHALL have states FREE, BUSY, ACCESS and ERROR.
REQ-017 A request is invalid when any of these holds: ramREN&ramWEN; ramaddr[1:0]!=0; ramaddr>=4*MEM_WORDS.
REQ-018 FREE: no request -> FREE; invalid request -> ERROR; valid request -> BUSY.
REQ-019 On entry to BUSY, the block SHALL latch addr/op/store and load the wait counter with LAT-1.
REQ-020 BUSY, request dropped: next state FREE, no SRAM access.
REQ-021 BUSY, request present but addr/op/store differ from the latched values: re-latch, reload the counter, stay in BUSY; an invalid new request goes to ERROR.
REQ-022 BUSY, counter>0 and request unchanged: decrement the counter.
REQ-023 BUSY, counter==0 and request unchanged: drive mem_en=1, mem_addr=latched word address, mem_wen=latched op==write, mem_wdata=latched store; next state ACCESS.
REQ-024 mem_en and mem_wen SHALL be 0 in every other cycle, and in any cycle where RST=1.
REQ-025 ACCESS SHALL last exactly one cycle; read: ramload=mem_rdata; write: ramload=0.
REQ-026 After ACCESS: no request -> FREE; valid request (same or new address) -> BUSY with counter reload; invalid request -> ERROR.
REQ-027 Every valid transaction SHALL spend exactly LAT cycles in BUSY followed by 1 cycle in ACCESS, so a burst of two words takes 2*(LAT+1) cycles.
REQ-028 ERROR: ramload=RAM_ERR_WORD; no SRAM access; stay in ERROR while ramREN|ramWEN; go to FREE when both are 0.
REQ-029 ramload SHALL be 0 in FREE and BUSY.
REQ-030 Exactly one SRAM write SHALL occur per completed write transaction; an aborted write (dropped, changed, or reset) SHALL write nothing.

Reset
REQ-031 RST=1 at a clock edge: state FREE, counter 0, latched addr/op/store 0.
REQ-032 Outputs after reset: ramstate=FREE, ramload=0, mem_en=0, mem_wen=0, mem_addr=0, mem_wdata=0.
REQ-033 Reset during BUSY or ACCESS SHALL abandon the transaction with no SRAM write and return to FREE on the next edge.

Structure
REQ-034 ramstate_t and word_t SHALL come from cpu_types_pkg; RAM_ERR_WORD=32'hBAD1BAD1 and RAM_LAT_DEFAULT=2 SHALL be added to cpu_types_pkg.
REQ-035 The wait counter SHALL be a sub-module ram_wait_counter (4-bit; load, decrement, zero flag).

Verification
REQ-036 LAT=2, read 0x0000_0010 with mem word 4=0xDEADBEEF -> BUSY, BUSY, ACCESS with ramload=0xDEADBEEF, then FREE after ramREN drops.
REQ-037 LAT=2, write 0xCAFEF00D to 0x0000_0020 -> exactly one mem_wen pulse with mem_addr=8 in the 2nd BUSY cycle; a readback returns 0xCAFEF00D.
REQ-038 Read 0x10 then 0x14 back-to-back, ramREN held -> B,B,A,B,B,A (6 cycles), with ramload 0x11111111 then 0x22222222 in the ACCESS cycles.
REQ-039 ramaddr changes 0x10 -> 0x30 during the 1st BUSY cycle -> counter reloads; ACCESS returns word 12; zero accesses to word 4.
REQ-040 ramaddr=0x0000_0013, or 0x0001_0000 with MEM_WORDS=16384, or ramREN=ramWEN=1 -> ERROR with ramload=0xBAD1BAD1 and mem_en=0 throughout; FREE one cycle after the request drops.
REQ-041 RST=1 in the final BUSY cycle of a write to 0x40 -> mem_wen stays 0, ramstate=FREE next cycle, word 16 unchanged.
